// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8N1 UART transmitter and receiver.
//   UART_OVERSAMPLE : default number of clken ticks per bit period
//   UART_DATA_W     : data bits per frame
//   ST_*            : 2-bit FSM state encodings (legacy-compatible constants)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_W     = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial input. Both flops reset
// to 1 so that a reset never looks like a start bit.
// Ports:
//   clk_50m : system clock, rising edge
//   rst     : synchronous reset, active-low
//   rx      : asynchronous serial input
//   rxs     : synchronized serial input (2 cycles of latency)
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk_50m,
    input  logic rst,
    input  logic rx,
    output logic rxs
);

    logic meta_r;

    // Two-stage shift into the clk_50m domain; idle-high reset value.
    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            meta_r <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            meta_r <= rx;
            rxs    <= meta_r;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver. Oversamples the synchronized rx line on clken ticks,
// samples each bit near its centre, checks the stop bit and hands the byte to
// the consumer on a rdy/rdy_clr handshake.
// Ports:
//   clk_50m   : system clock, rising edge
//   rst       : synchronous reset, active-low
//   rx        : asynchronous serial input, idle high
//   clken     : single-cycle tick at OVERSAMPLE x baud rate
//   rdy_clr   : consumer acknowledge, clears rdy / frame_err / overrun
//   dout      : last correctly framed byte
//   rdy       : dout holds an unread byte
//   frame_err : sticky, a stop bit was sampled low
//   overrun   : sticky, a byte completed while rdy was still set
//   rx_busy   : receiver is inside a frame (state not IDLE)
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic                   rx,
    input  logic                   clken,
    input  logic                   rdy_clr,
    output logic [UART_DATA_W-1:0] dout,
    output logic                   rdy,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   rx_busy
);

    localparam int unsigned        CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]   CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic                   rxs_s;
    logic [1:0]             state_r,   state_s;
    logic [CNT_W-1:0]       cnt_r,     cnt_s;
    logic [2:0]             idx_r,     idx_s;
    logic [UART_DATA_W-1:0] shreg_r,   shreg_s;
    logic [UART_DATA_W-1:0] dout_r,    dout_s;
    logic                   rdy_r,     rdy_s;
    logic                   fe_r,      fe_s;
    logic                   ov_r,      ov_s;
    logic                   busy_r;
    logic                   done_ok_s;
    logic                   done_bad_s;

    uart_rx_sync u_sync (
        .clk_50m (clk_50m),
        .rst     (rst),
        .rx      (rx),
        .rxs     (rxs_s)
    );

    // Frame FSM: tick counter, bit index and shift register next-state.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        shreg_s    = shreg_r;
        done_ok_s  = 1'b0;
        done_bad_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                idx_s = 3'd0;
                if (clken && !rxs_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (clken) begin
                    if (cnt_r == CNT_MID) begin
                        // Mid-start-bit: a high level here was only a glitch.
                        cnt_s = '0;
                        if (!rxs_s) begin
                            state_s = ST_DATA;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_DATA: begin
                if (clken) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_s          = '0;
                        shreg_s[idx_r] = rxs_s;
                        if (idx_r == 3'd7) begin
                            idx_s   = 3'd0;
                            state_s = ST_STOP;
                        end else begin
                            idx_s = idx_r + 3'd1;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_STOP: begin
                if (clken) begin
                    if (cnt_r == CNT_LAST) begin
                        // Leave at mid-stop-bit so the next start edge is seen.
                        cnt_s   = '0;
                        state_s = ST_IDLE;
                        if (rxs_s) begin
                            done_ok_s = 1'b1;
                        end else begin
                            done_bad_s = 1'b1;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                idx_s   = 3'd0;
            end
        endcase
    end

    // Output flags: a completion on the same edge as rdy_clr wins.
    always_comb begin
        dout_s = dout_r;
        rdy_s  = rdy_r;
        fe_s   = fe_r;
        ov_s   = ov_r;
        if (done_ok_s) begin
            dout_s = shreg_r;
            rdy_s  = 1'b1;
        end else if (rdy_clr) begin
            rdy_s = 1'b0;
        end else begin
            rdy_s = rdy_r;
        end
        if (done_bad_s) begin
            fe_s = 1'b1;
        end else if (rdy_clr) begin
            fe_s = 1'b0;
        end else begin
            fe_s = fe_r;
        end
        if (rdy_clr) begin
            ov_s = 1'b0;
        end else begin
            ov_s = ov_r | (done_ok_s & rdy_r);
        end
    end

    // State and output registers; reset drops any frame in progress silently.
    always_ff @(posedge clk_50m) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shreg_r <= '0;
            dout_r  <= '0;
            rdy_r   <= 1'b0;
            fe_r    <= 1'b0;
            ov_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shreg_r <= shreg_s;
            dout_r  <= dout_s;
            rdy_r   <= rdy_s;
            fe_r    <= fe_s;
            ov_r    <= ov_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign dout      = dout_r;
    assign rdy       = rdy_r;
    assign frame_err = fe_r;
    assign overrun   = ov_r;
    assign rx_busy   = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Scoreboard bench: each stimulus pushes the expected {dout,rdy,frame_err,
// overrun} into a queue; a monitor pops and compares whenever rx_busy falls
// (end of frame, glitch rejection, or reset). clken ticks every 4 clocks, so
// one bit period at OVERSAMPLE=16 is 64 clocks.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    typedef struct packed {
        logic [7:0] dout;
        logic       rdy;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b0;
    logic       rx      = 1'b1;
    logic       rdy_clr = 1'b0;
    logic       clken;
    logic [1:0] tick_cnt = 2'd0;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_frame = 0;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .rx        (rx),
        .clken     (clken),
        .rdy_clr   (rdy_clr),
        .dout      (dout),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk_50m = ~clk_50m;

    // Baud tick: one clk_50m cycle in four.
    always @(posedge clk_50m) tick_cnt <= tick_cnt + 2'd1;
    assign clken = (tick_cnt == 2'd0);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Return just after a clken edge so frame timing is deterministic.
    task automatic align();
        do @(negedge clk_50m); while (tick_cnt != 2'd0);
        @(negedge clk_50m);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    // Send one 8N1 frame. A bad stop bit is held low only until just after the
    // stop sample so it is not mistaken for a new start bit. clr_at_stop
    // pulses rdy_clr on exactly the stop-sample edge (35 negedges into the bit).
    task automatic send(input logic [7:0] d, input logic stop_ok, input logic clr_at_stop);
        align();
        rx = 1'b0;
        hold(64);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            hold(64);
        end
        if (!stop_ok) begin
            rx = 1'b0;
            hold(37);
            rx = 1'b1;
            hold(27);
        end else if (clr_at_stop) begin
            rx = 1'b1;
            hold(35);
            rdy_clr = 1'b1;
            hold(1);
            rdy_clr = 1'b0;
            hold(28);
        end else begin
            rx = 1'b1;
            hold(64);
        end
        rx = 1'b1;
        hold(8);
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        hold(1);
        rdy_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic r, input logic f, input logic o);
        exp_t e;
        e.dout = d;
        e.rdy  = r;
        e.fe   = f;
        e.ov   = o;
        exp_q.push_back(e);
    endtask

    // Monitor: compare against the scoreboard on every rx_busy falling edge.
    initial begin
        logic busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk_50m);
            if (busy_prev === 1'b1 && rx_busy === 1'b0) begin
                n_frame++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_end_of_frame: got %0h, expected none",
                             {dout, rdy, frame_err, overrun});
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("event%0d", n_frame),
                          {5'd0, dout, rdy, frame_err, overrun}, {5'd0, e});
                end
            end
            busy_prev = rx_busy;
        end
    end

    // Directed stimulus.
    initial begin
        hold(3);
        check("reset_dout", {8'd0, dout}, 16'h0000);
        check("reset_flags", {12'd0, rdy, frame_err, overrun, rx_busy}, 16'h0000);
        rst = 1'b1;
        hold(4);

        // Single byte, then acknowledge.
        push(8'hA5, 1'b1, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        pulse_clr();
        check("clr_rdy", {15'd0, rdy}, 16'h0000);
        check("clr_keeps_dout", {8'd0, dout}, 16'h00A5);

        // Glitch shorter than half a bit.
        push(8'hA5, 1'b0, 1'b0, 1'b0);
        align();
        rx = 1'b0;
        hold(16);
        rx = 1'b1;
        hold(64);
        check("glitch_idle", {15'd0, rx_busy}, 16'h0000);

        // Framing error keeps the previous byte.
        push(8'hA5, 1'b0, 1'b1, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        pulse_clr();
        check("fe_cleared", {14'd0, frame_err, rdy}, 16'h0000);

        // Overrun.
        push(8'h11, 1'b1, 1'b0, 1'b0);
        send(8'h11, 1'b1, 1'b0);
        push(8'h22, 1'b1, 1'b0, 1'b1);
        send(8'h22, 1'b1, 1'b0);
        pulse_clr();
        check("ov_cleared", {14'd0, overrun, rdy}, 16'h0000);

        // Acknowledge on the completion edge: completion wins, no overrun.
        push(8'h11, 1'b1, 1'b0, 1'b0);
        send(8'h11, 1'b1, 1'b0);
        push(8'h22, 1'b1, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b1);
        check("clr_race_rdy", {14'd0, rdy, overrun}, 16'h0002);

        // Reset in the middle of data bit 4 of 0xFF.
        push(8'h00, 1'b0, 1'b0, 1'b0);
        align();
        rx = 1'b0;
        hold(64);
        rx = 1'b1;
        hold(4 * 64 + 32);
        rst = 1'b0;
        hold(3);
        rst = 1'b1;
        check("midrst_dout", {8'd0, dout}, 16'h0000);
        check("midrst_flags", {12'd0, rdy, frame_err, overrun, rx_busy}, 16'h0000);
        hold(64);

        push(8'h5A, 1'b1, 1'b0, 1'b0);
        send(8'h5A, 1'b1, 1'b0);

        hold(20);
        check("scoreboard_drained", exp_q.size(), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
